param_bus_mux: RTL and testbench
================================

Name: param_bus_mux

Overview:
- Parametrised, registered successor to the datapath's single-driver bus multiplexer.
- Selects one of NSRC source words of WIDTH bits onto the shared bus using per-source "out" enables.
- Adds a pipeline register with hold, a selectable idle policy, sticky multi-driver conflict detection with capture, and a saturating transfer counter.
- Sits between the register file/special registers (PC, MAR, MDR, IR, HI, LO, Y, Z) and every bus consumer.

Parameters:
- WIDTH, 32, bits per source and bus word
- NSRC, 25, number of bus sources; index 0 is lowest priority
- REG_OUT, 1, 1 = bus outputs registered (1-cycle latency); 0 = combinational path, no hold
- IDLE_HOLD, 0, 0 = idle bus drives zero; 1 = idle bus retains last driven word
- CNTW, 16, transfer counter width
- SELW, $clog2(NSRC), width of the source index

Ports:
- clock  in  1  rising-edge clock
- clear_n  in  1  asynchronous active-low reset
- src_data  in  NSRC*WIDTH  source words packed; source i at [i*WIDTH +: WIDTH]
- src_out  in  NSRC  per-source drive enables, nominally one-hot
- hold  in  1  freeze bus_out/bus_valid/bus_sel (REG_OUT=1 only)
- err_clr  in  1  synchronous clear of conflict state
- bus_out  out  WIDTH  bus word
- bus_valid  out  1  a source drove the bus for this word
- bus_sel  out  SELW  index of the driving source
- conflict  out  1  sticky: two or more enables seen in one cycle
- conflict_mask  out  NSRC  src_out captured at the first conflict
- xfer_count  out  CNTW  saturating count of valid transfers

Behaviour:
- Asynchronous clear_n low sets every output and all internal state to 0, with or without a clock.
- Release is synchronous to the next rising edge.
- Selection (combinational):
  - winner = highest index i with src_out[i]=1; a higher index always overrides a lower one.
  - any = OR of src_out.
  - Next word: src_data[winner] if any=1. If any=0, use 0 when IDLE_HOLD=0, or the current bus_out when IDLE_HOLD=1.
  - Next bus_sel: winner if any=1. If any=0, use 0 when IDLE_HOLD=0, or hold the current value when IDLE_HOLD=1.
- REG_OUT=1:
  - Each edge with hold=0: bus_out, bus_valid(=any), bus_sel load the next values. Latency is 1 cycle from src_out to bus_out.
  - hold=1: all three retain their values; bus_valid is not regenerated.
- REG_OUT=0:
  - bus_out, bus_valid, bus_sel are combinational from the current inputs.
  - hold is ignored.
  - IDLE_HOLD=1 retains the word in an internal register updated on every edge where any=1.
- Conflict detection runs every cycle, independent of hold.
  - multi = (popcount(src_out) >= 2).
  - Edge with multi=1 and conflict=0: conflict <= 1, conflict_mask <= src_out.
  - Edge with multi=1 and conflict=1: mask unchanged (first conflict kept).
  - Edge with err_clr=1 and multi=0: conflict <= 0, conflict_mask <= 0.
  - Edge with err_clr=1 and multi=1: conflict stays 1 and conflict_mask <= current src_out (clear and re-capture).
  - The data path still resolves a conflict by priority; conflict has no effect on bus_out.
- xfer_count:
  - Increments on each edge where a valid word is loaded: any=1, and hold=0 when REG_OUT=1.
  - Saturates at 2^CNTW-1 and never wraps.
  - Reset only by clear_n.
- Parameter rules: NSRC>=2, WIDTH>=1. src_out bits at or above NSRC do not exist; no X propagation from unused slices.

Test Plan:
- NSRC=4, WIDTH=8, REG_OUT=1, IDLE_HOLD=0; src_data={0xD4,0xC3,0xB2,0xA1}, src_out=0100 -> one edge later bus_out=0xC3, bus_sel=2, bus_valid=1, xfer_count=1, conflict=0.
- src_out=1010 -> bus_out=0xD4, bus_sel=3, conflict=1, conflict_mask=1010. Next cycle src_out=0011 -> mask stays 1010. Then err_clr=1 with src_out=0000 -> conflict=0, mask=0000.
- err_clr=1 together with src_out=0110 -> conflict stays 1, conflict_mask=0110, bus_out=0xC3.
- hold=1 for 3 cycles while src_out=0001 -> bus_out stays at its previous value, xfer_count unchanged; conflict logic still active. hold=0 -> bus_out=0xA1 next edge.
- Idle policy: src_out=0000. IDLE_HOLD=0 -> bus_out=0x00, bus_valid=0. IDLE_HOLD=1 -> bus_out keeps last word 0xA1, bus_valid=0.
- CNTW=3, src_out=0001 continuously for 10 cycles -> xfer_count 1..7 then stays 7.
- Pull clear_n low mid-stream without a clock edge -> all outputs 0 immediately.
- REG_OUT=0: src_out=0010 -> bus_out=0xB2 in the same cycle.

Source files
------------

// File: rtl/param_bus_mux.sv
// rtl/param_bus_mux.sv - registered priority bus multiplexer with conflict capture and transfer counter
module param_bus_mux #(
  parameter int WIDTH     = 32,
  parameter int NSRC      = 25,
  parameter int REG_OUT   = 1,
  parameter int IDLE_HOLD = 0,
  parameter int CNTW      = 16,
  parameter int SELW      = $clog2(NSRC)
) (
  input  logic                    clock,
  input  logic                    clear_n,
  input  logic [NSRC*WIDTH-1:0]   src_data,
  input  logic [NSRC-1:0]         src_out,
  input  logic                    hold,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        bus_out,
  output logic                    bus_valid,
  output logic [SELW-1:0]         bus_sel,
  output logic                    conflict,
  output logic [NSRC-1:0]         conflict_mask,
  output logic [CNTW-1:0]         xfer_count
);

  localparam logic [CNTW-1:0] CountMax = {CNTW{1'b1}};

  logic [WIDTH-1:0] pickWord;
  logic [WIDTH-1:0] nextWord;
  logic [WIDTH-1:0] wordQ;
  logic [SELW-1:0]  winner;
  logic [SELW-1:0]  nextSel;
  logic [SELW-1:0]  selQ;
  logic             anySrc;
  logic             multiSrc;
  logic             validQ;
  logic             loadValid;
  logic             conflictQ;
  logic [NSRC-1:0]  maskQ;
  logic [CNTW-1:0]  xferQ;

  // Priority resolve: the last set enable scanned (highest index) wins; a second set bit flags multi-drive.
  always_comb begin
    winner   = '0;
    pickWord = '0;
    anySrc   = 1'b0;
    multiSrc = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_out[i]) begin
        multiSrc = multiSrc | anySrc;
        anySrc   = 1'b1;
        winner   = SELW'(i);
        pickWord = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Idle policy: either park the bus at zero or keep presenting the last driven word and index.
  always_comb begin
    nextWord = '0;
    nextSel  = '0;
    if (anySrc) begin
      nextWord = pickWord;
      nextSel  = winner;
    end else if (IDLE_HOLD != 0) begin
      nextWord = wordQ;
      nextSel  = selQ;
    end
  end

  // A transfer counts when a driven word is accepted; hold only stalls the registered variant.
  assign loadValid = anySrc && ((REG_OUT == 0) || !hold);

  // Bus word register: pipeline stage when registered, otherwise the retention store for the idle word.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wordQ  <= '0;
      selQ   <= '0;
      validQ <= 1'b0;
    end else if (REG_OUT != 0) begin
      if (!hold) begin
        wordQ  <= nextWord;
        selQ   <= nextSel;
        validQ <= anySrc;
      end
    end else if (anySrc) begin
      wordQ  <= pickWord;
      selQ   <= winner;
      validQ <= 1'b1;
    end
  end

  // Sticky conflict capture; err_clr coinciding with a new conflict re-arms on the current enables.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      conflictQ <= 1'b0;
      maskQ     <= '0;
    end else if (err_clr) begin
      conflictQ <= multiSrc;
      maskQ     <= multiSrc ? src_out : '0;
    end else if (multiSrc && !conflictQ) begin
      conflictQ <= 1'b1;
      maskQ     <= src_out;
    end
  end

  // Saturating transfer counter, cleared only by reset.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      xferQ <= '0;
    end else if (loadValid && (xferQ != CountMax)) begin
      xferQ <= xferQ + 1'b1;
    end
  end

  // The combinational variant is forced to zero during reset so every output reads 0 while clear_n is low.
  assign bus_out       = (REG_OUT != 0) ? wordQ  : (clear_n ? nextWord : '0);
  assign bus_sel       = (REG_OUT != 0) ? selQ   : (clear_n ? nextSel  : '0);
  assign bus_valid     = (REG_OUT != 0) ? validQ : (clear_n && anySrc);
  assign conflict      = conflictQ;
  assign conflict_mask = maskQ;
  assign xfer_count    = xferQ;

endmodule

// File: tb/tb_param_bus_mux.sv
// tb/tb_param_bus_mux.sv - directed self-checking bench for param_bus_mux
module tb_param_bus_mux;

  logic        clock;
  logic        clear_n;
  logic [31:0] src_data;
  logic [3:0]  src_out;
  logic        hold;
  logic        err_clr;

  logic [7:0]  busA, busB, busC, busD;
  logic        validA, validB, validC, validD;
  logic [1:0]  selA, selB, selC, selD;
  logic        confA, confB, confC, confD;
  logic [3:0]  maskA, maskB, maskC, maskD;
  logic [15:0] cntA, cntB, cntD;
  logic [2:0]  cntC;

  int testsRun;
  int testsFailed;

  // A: registered, idle zero (main config)
  param_bus_mux #(.WIDTH(8), .NSRC(4), .REG_OUT(1), .IDLE_HOLD(0), .CNTW(16)) dutA (
    .clock(clock), .clear_n(clear_n), .src_data(src_data), .src_out(src_out),
    .hold(hold), .err_clr(err_clr), .bus_out(busA), .bus_valid(validA), .bus_sel(selA),
    .conflict(confA), .conflict_mask(maskA), .xfer_count(cntA));

  // B: registered, idle holds last word
  param_bus_mux #(.WIDTH(8), .NSRC(4), .REG_OUT(1), .IDLE_HOLD(1), .CNTW(16)) dutB (
    .clock(clock), .clear_n(clear_n), .src_data(src_data), .src_out(src_out),
    .hold(hold), .err_clr(err_clr), .bus_out(busB), .bus_valid(validB), .bus_sel(selB),
    .conflict(confB), .conflict_mask(maskB), .xfer_count(cntB));

  // C: narrow counter for saturation
  param_bus_mux #(.WIDTH(8), .NSRC(4), .REG_OUT(1), .IDLE_HOLD(0), .CNTW(3)) dutC (
    .clock(clock), .clear_n(clear_n), .src_data(src_data), .src_out(src_out),
    .hold(hold), .err_clr(err_clr), .bus_out(busC), .bus_valid(validC), .bus_sel(selC),
    .conflict(confC), .conflict_mask(maskC), .xfer_count(cntC));

  // D: combinational path with idle retention
  param_bus_mux #(.WIDTH(8), .NSRC(4), .REG_OUT(0), .IDLE_HOLD(1), .CNTW(16)) dutD (
    .clock(clock), .clear_n(clear_n), .src_data(src_data), .src_out(src_out),
    .hold(hold), .err_clr(err_clr), .bus_out(busD), .bus_valid(validD), .bus_sel(selD),
    .conflict(confD), .conflict_mask(maskD), .xfer_count(cntD));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    clear_n  = 1'b0;
    src_data = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    src_out  = 4'b0000;
    hold     = 1'b0;
    err_clr  = 1'b0;

    #1;
    check("reset_bus",   32'(busA),   32'h0);
    check("reset_valid", 32'(validA), 32'h0);
    check("reset_count", 32'(cntA),   32'h0);
    step();
    step();
    clear_n = 1'b1;

    // single source
    src_out = 4'b0100;
    step();
    check("single_bus",   32'(busA),   32'hC3);
    check("single_sel",   32'(selA),   32'h2);
    check("single_valid", 32'(validA), 32'h1);
    check("single_count", 32'(cntA),   32'h1);
    check("single_conf",  32'(confA),  32'h0);
    check("comb_single",  32'(busD),   32'hC3);

    // conflict capture
    src_out = 4'b1010;
    step();
    check("conf_bus",  32'(busA),  32'hD4);
    check("conf_sel",  32'(selA),  32'h3);
    check("conf_flag", 32'(confA), 32'h1);
    check("conf_mask", 32'(maskA), 32'hA);

    src_out = 4'b0011;
    step();
    check("conf2_mask_kept", 32'(maskA), 32'hA);
    check("conf2_bus",       32'(busA),  32'hB2);
    check("conf2_count",     32'(cntA),  32'h3);

    // clear with idle bus
    err_clr = 1'b1;
    src_out = 4'b0000;
    step();
    check("clr_flag",      32'(confA),  32'h0);
    check("clr_mask",      32'(maskA),  32'h0);
    check("idle0_bus",     32'(busA),   32'h0);
    check("idle0_valid",   32'(validA), 32'h0);
    check("idle0_sel",     32'(selA),   32'h0);
    check("idle1_bus",     32'(busB),   32'hB2);
    check("idle1_valid",   32'(validB), 32'h0);
    check("idle1_sel",     32'(selB),   32'h1);

    // clear coinciding with a new conflict
    src_out = 4'b0110;
    step();
    check("reclr_flag", 32'(confA), 32'h1);
    check("reclr_mask", 32'(maskA), 32'h6);
    check("reclr_bus",  32'(busA),  32'hC3);
    check("reclr_cnt",  32'(cntA),  32'h4);

    // hold: data frozen, conflict logic live
    hold    = 1'b1;
    err_clr = 1'b1;
    src_out = 4'b0001;
    step();
    check("hold1_bus",  32'(busA),  32'hC3);
    check("hold1_cnt",  32'(cntA),  32'h4);
    check("hold1_conf", 32'(confA), 32'h0);
    check("hold1_mask", 32'(maskA), 32'h0);
    err_clr = 1'b0;
    src_out = 4'b1001;
    step();
    check("hold2_bus",  32'(busA),  32'hC3);
    check("hold2_sel",  32'(selA),  32'h2);
    check("hold2_conf", 32'(confA), 32'h1);
    check("hold2_mask", 32'(maskA), 32'h9);
    src_out = 4'b0001;
    step();
    check("hold3_bus",   32'(busA),   32'hC3);
    check("hold3_valid", 32'(validA), 32'h1);
    check("hold3_cnt",   32'(cntA),   32'h4);
    hold = 1'b0;
    step();
    check("unhold_bus", 32'(busA), 32'hA1);
    check("unhold_sel", 32'(selA), 32'h0);
    check("unhold_cnt", 32'(cntA), 32'h5);

    // idle policies
    src_out = 4'b0000;
    step();
    check("idle0b_bus",   32'(busA),   32'h0);
    check("idle0b_valid", 32'(validA), 32'h0);
    check("idle1b_bus",   32'(busB),   32'hA1);
    check("idle1b_valid", 32'(validB), 32'h0);
    check("comb_idle_bus",   32'(busD),   32'hA1);
    check("comb_idle_valid", 32'(validD), 32'h0);

    // combinational path responds without an edge
    src_out = 4'b0010;
    #1;
    check("comb_bus",   32'(busD),   32'hB2);
    check("comb_sel",   32'(selD),   32'h1);
    check("comb_valid", 32'(validD), 32'h1);
    check("reg_latency_bus", 32'(busA), 32'h0);
    step();
    check("reg_bus_b2", 32'(busA), 32'hB2);
    check("reg_cnt_6",  32'(cntA), 32'h6);

    // asynchronous reset mid-stream
    src_out = 4'b0001;
    step();
    check("pre_rst_bus", 32'(busA), 32'hA1);
    #2;
    clear_n = 1'b0;
    #1;
    check("arst_bus",   32'(busA),   32'h0);
    check("arst_valid", 32'(validA), 32'h0);
    check("arst_sel",   32'(selA),   32'h0);
    check("arst_conf",  32'(confA),  32'h0);
    check("arst_mask",  32'(maskA),  32'h0);
    check("arst_cnt",   32'(cntA),   32'h0);
    check("arst_comb",  32'(busD),   32'h0);
    step();
    clear_n = 1'b1;

    // counter saturation with CNTW=3
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("sat_cnt_%0d", k), 32'(cntC), (k < 7) ? 32'(k) : 32'd7);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
